// File: rtl/decode_issue_buffer.sv
// Decode-to-execute issue buffer: circular queue of decoded payloads with
// valid/ready handshakes, mispredict flush, hazard bubbles and a stall counter.
module decode_issue_buffer #(
  parameter int PAYLOAD_WIDTH   = 160,
  parameter int DEPTH           = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]     in_payload,
  input  logic                         in_hazard,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_WIDTH-1:0]     out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cycles
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PAYLOAD_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       push_s, pop_s, stall_s;

  // Pointer increment with wrap at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign in_ready     = (count_q != CNT_W'(DEPTH));
  assign out_valid    = (count_q != CNT_W'(0));
  assign out_payload  = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign stall_cycles = stall_q;

  // Handshake qualification and next-state for pointers, occupancy and stall counter.
  always_comb begin
    push_s   = in_valid & in_ready & ~in_hazard & ~flush;
    pop_s    = out_valid & out_ready & ~flush;
    stall_s  = out_valid & ~out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Stall counter keeps running across flushes; only reset clears it.
    if (stall_s && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_payload;
    end
  end

endmodule
